// File: rtl/wb_decoder_2_if.sv
// wb_decoder_2_if: one Wishbone B4 pipelined bus segment
// Signals: adr/dat_w/we/sel/stb/cyc travel master->slave; dat_r/ack/err/stall travel slave->master.
// Modports: master (the side issuing requests), slave (the side answering them).
interface wb_decoder_2_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat_w;
    logic [DATA_WIDTH-1:0]   dat_r;
    logic                    we;
    logic [SELECT_WIDTH-1:0] sel;
    logic                    stb;
    logic                    cyc;
    logic                    ack;
    logic                    err;
    logic                    stall;

    modport master (output adr, dat_w, we, sel, stb, cyc, input dat_r, ack, err, stall);
    modport slave  (input adr, dat_w, we, sel, stb, cyc, output dat_r, ack, err, stall);
endinterface

// File: rtl/wb_decoder_2.sv
// wb_decoder_2: Wishbone B4 pipelined 1-to-2 address decoder with outstanding-request tracking
// Ports: clk  - system clock
//        rst  - synchronous reset, active low
//        wbm  - upstream bus from the master (slave modport)
//        wbs0 - downstream bus to slave 0 (master modport)
//        wbs1 - downstream bus to slave 1 (master modport)
module wb_decoder_2 #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    SELECT_WIDTH = DATA_WIDTH / 8,
    parameter logic [ADDR_WIDTH-1:0] S0_BASE      = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] S0_MASK      = 32'hF000_0000,
    parameter logic [ADDR_WIDTH-1:0] S1_BASE      = 32'h1000_0000,
    parameter logic [ADDR_WIDTH-1:0] S1_MASK      = 32'hF000_0000,
    parameter int                    MAX_PENDING  = 4
) (
    input logic            clk,
    input logic            rst,
    wb_decoder_2_if.slave  wbm,
    wb_decoder_2_if.master wbs0,
    wb_decoder_2_if.master wbs1
);
    localparam int PW = $clog2(MAX_PENDING + 1);

    typedef enum logic [1:0] {IDLE, BUSY, ERR_RSP} state_t;

    state_t                  state, state_n;
    logic                    act, act_n;
    logic                    err_q, err_n;
    logic [PW-1:0]           pend, pend_n;
    logic                    hit0, hit1, mapped, tgt, req, resp, stall_int, accept, stb0, stb1;
    logic [SELECT_WIDTH-1:0] sel;

    assign hit0   = (wbm.adr & S0_MASK) == S0_BASE;
    assign hit1   = (wbm.adr & S1_MASK) == S1_BASE;
    assign mapped = hit0 | hit1;
    assign tgt    = !hit0;
    assign req    = wbm.cyc & wbm.stb;

    // Only the active slave completes requests, only while the cycle is alive,
    // and never when nothing is outstanding.
    assign resp = state == BUSY && wbm.cyc && pend != '0 &&
                  (act ? (wbs1.ack | wbs1.err) : (wbs0.ack | wbs0.err));

    // Stall reasons owned by the decoder itself; the slave's own stall is
    // added on top for wbm.stall but must not suppress stb to the slave.
    assign stall_int = state == ERR_RSP ||
                       (state == BUSY && (!mapped || tgt != act)) ||
                       (pend == PW'(MAX_PENDING) && !resp);

    assign stb0      = rst && req && mapped && !tgt && !stall_int;
    assign stb1      = rst && req && mapped && tgt && !stall_int;
    assign wbm.stall = !rst || stall_int || (mapped && (tgt ? wbs1.stall : wbs0.stall));
    assign accept    = req && !wbm.stall;

    assign wbs0.stb = stb0;
    assign wbs1.stb = stb1;
    assign wbs0.cyc = rst && wbm.cyc && ((state == BUSY && !act) || stb0);
    assign wbs1.cyc = rst && wbm.cyc && ((state == BUSY && act) || stb1);

    assign sel        = wbm.sel;
    assign wbs0.adr   = wbm.adr;
    assign wbs1.adr   = wbm.adr;
    assign wbs0.dat_w = wbm.dat_w;
    assign wbs1.dat_w = wbm.dat_w;
    assign wbs0.we    = wbm.we;
    assign wbs1.we    = wbm.we;
    assign wbs0.sel   = sel;
    assign wbs1.sel   = sel;

    assign wbm.ack   = rst && state == BUSY && wbm.cyc && (act ? wbs1.ack : wbs0.ack);
    assign wbm.err   = rst && (err_q || (state == BUSY && wbm.cyc && (act ? wbs1.err : wbs0.err)));
    assign wbm.dat_r = state == BUSY ? (act ? wbs1.dat_r : wbs0.dat_r) : '0;

    always_comb begin
        state_n = state;
        act_n   = act;
        pend_n  = pend;
        err_n   = 1'b0;
        if (!wbm.cyc) begin
            state_n = IDLE;
            pend_n  = '0;
        end else if (state == IDLE) begin
            if (accept && mapped) begin
                state_n = BUSY;
                act_n   = tgt;
                pend_n  = PW'(1);
            end else if (accept) begin
                state_n = ERR_RSP;
                err_n   = 1'b1;
            end
        end else if (state == BUSY) begin
            pend_n  = pend + PW'(accept) - PW'(resp);
            state_n = pend_n == '0 ? IDLE : BUSY;
        end else begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            act   <= 1'b0;
            pend  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            act   <= act_n;
            pend  <= pend_n;
            err_q <= err_n;
        end
    end
endmodule

// File: tb/tb_wb_decoder_2.sv
// tb_wb_decoder_2: directed self-checking bench for wb_decoder_2
module tb_wb_decoder_2;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    wb_decoder_2_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4)) m ();
    wb_decoder_2_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4)) s0 ();
    wb_decoder_2_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4)) s1 ();

    wb_decoder_2 dut (.clk(clk), .rst(rst), .wbm(m), .wbs0(s0), .wbs1(s1));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic mreq(input logic c, input logic s, input logic [31:0] a, input logic w);
        m.cyc   = c;
        m.stb   = s;
        m.adr   = a;
        m.we    = w;
        m.dat_w = a ^ 32'h5A5A_5A5A;
        m.sel   = 4'hF;
    endtask

    task automatic slv(input logic a0, input logic [31:0] d0, input logic a1, input logic [31:0] d1);
        s0.ack   = a0;
        s0.dat_r = d0;
        s0.err   = 1'b0;
        s1.ack   = a1;
        s1.dat_r = d1;
        s1.err   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        s0.stall = 1'b0;
        s1.stall = 1'b0;
        mreq(1, 1, 32'h10, 0);
        slv(1, 32'h1, 0, 0);
        tick();
        tick();
        #1;
        total++; if (m.stall !== 1'b1) begin bad++; $display("FAIL rst_stall: got %b want 1", m.stall); end
        total++; if (m.ack !== 1'b0) begin bad++; $display("FAIL rst_ack: got %b want 0", m.ack); end
        total++; if (m.err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", m.err); end
        total++; if (s0.cyc !== 1'b0 || s0.stb !== 1'b0) begin bad++; $display("FAIL rst_s0: got cyc=%b stb=%b want 0/0", s0.cyc, s0.stb); end
        total++; if (s1.cyc !== 1'b0 || s1.stb !== 1'b0) begin bad++; $display("FAIL rst_s1: got cyc=%b stb=%b want 0/0", s1.cyc, s1.stb); end
        rst = 1'b1;
        mreq(1, 0, 32'h10, 0);
        tick();
        #1;
        total++; if (m.ack !== 1'b0) begin bad++; $display("FAIL rst_release_ack: got %b want 0", m.ack); end
        tick();
        mreq(0, 0, 32'h0, 0);
        slv(0, 32'h0, 0, 32'h0);
    endtask

    task automatic test_single_read();
        tick();
        mreq(1, 1, 32'h10, 0);
        slv(0, 32'h0, 0, 32'h0);
        #1;
        total++; if (s0.stb !== 1'b1) begin bad++; $display("FAIL rd_stb0: got %b want 1", s0.stb); end
        total++; if (m.stall !== 1'b0) begin bad++; $display("FAIL rd_stall: got %b want 0", m.stall); end
        total++; if (s1.cyc !== 1'b0 || s1.stb !== 1'b0) begin bad++; $display("FAIL rd_s1_idle: got cyc=%b stb=%b want 0/0", s1.cyc, s1.stb); end
        total++; if (s0.adr !== 32'h10 || s1.adr !== 32'h10) begin bad++; $display("FAIL rd_adr_bcast: got %h/%h want 00000010", s0.adr, s1.adr); end
        total++; if (s1.dat_w !== 32'h5A5A_5A4A) begin bad++; $display("FAIL rd_dat_bcast: got %h want 5a5a5a4a", s1.dat_w); end
        tick();
        mreq(1, 0, 32'h10, 0);
        slv(1, 32'hDEAD_BEEF, 0, 32'h0);
        #1;
        total++; if (m.ack !== 1'b1) begin bad++; $display("FAIL rd_ack: got %b want 1", m.ack); end
        total++; if (m.dat_r !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_dat: got %h want deadbeef", m.dat_r); end
        total++; if (s0.stb !== 1'b0 || s0.cyc !== 1'b1) begin bad++; $display("FAIL rd_s0_resp: got stb=%b cyc=%b want 0/1", s0.stb, s0.cyc); end
        total++; if (s1.cyc !== 1'b0) begin bad++; $display("FAIL rd_s1cyc: got %b want 0", s1.cyc); end
        tick();
        slv(0, 32'h0, 0, 32'h0);
        #1;
        total++; if (m.ack !== 1'b0 || s0.cyc !== 1'b0) begin bad++; $display("FAIL rd_done: got ack=%b cyc0=%b want 0/0", m.ack, s0.cyc); end
        mreq(0, 0, 32'h0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            tick();
            mreq(1, 1, 32'h1000_0000 + 32'(4 * i), 1);
            slv(0, 32'h0, 0, 32'h0);
            #1;
            total++; if (s1.stb !== 1'b1 || m.stall !== 1'b0) begin bad++; $display("FAIL b2b_acc%0d: got stb1=%b stall=%b want 1/0", i, s1.stb, m.stall); end
        end
        total++; if (s1.we !== 1'b1 || s0.stb !== 1'b0) begin bad++; $display("FAIL b2b_we: got we=%b stb0=%b want 1/0", s1.we, s0.stb); end
        tick();
        mreq(1, 1, 32'h1000_0010, 1);
        #1;
        total++; if (m.stall !== 1'b1 || s1.stb !== 1'b0) begin bad++; $display("FAIL b2b_full: got stall=%b stb1=%b want 1/0", m.stall, s1.stb); end
        total++; if (s1.cyc !== 1'b1) begin bad++; $display("FAIL b2b_cyc1: got %b want 1", s1.cyc); end
        tick();
        slv(0, 32'h0, 1, 32'h11);
        #1;
        total++; if (m.stall !== 1'b0 || s1.stb !== 1'b1) begin bad++; $display("FAIL b2b_fifth: got stall=%b stb1=%b want 0/1", m.stall, s1.stb); end
        total++; if (m.ack !== 1'b1 || m.dat_r !== 32'h11) begin bad++; $display("FAIL b2b_ack0: got ack=%b dat=%h want 1/00000011", m.ack, m.dat_r); end
        for (int i = 1; i < 5; i++) begin
            tick();
            mreq(1, 0, 32'h1000_0010, 1);
            slv(0, 32'h0, 1, 32'h11 + 32'(i));
            #1;
            total++; if (m.ack !== 1'b1) begin bad++; $display("FAIL b2b_ack%0d: got %b want 1", i, m.ack); end
        end
        tick();
        #1;
        total++; if (m.ack !== 1'b0 || s1.cyc !== 1'b0) begin bad++; $display("FAIL b2b_extra_ack: got ack=%b cyc1=%b want 0/0", m.ack, s1.cyc); end
        tick();
        mreq(0, 0, 32'h0, 0);
        slv(0, 32'h0, 0, 32'h0);
    endtask

    task automatic test_conflict();
        tick();
        mreq(1, 1, 32'h0, 1);
        #1;
        total++; if (s0.stb !== 1'b1) begin bad++; $display("FAIL cf_first: got %b want 1", s0.stb); end
        tick();
        mreq(1, 1, 32'h1000_0000, 1);
        #1;
        total++; if (m.stall !== 1'b1 || s1.stb !== 1'b0 || s1.cyc !== 1'b0) begin bad++; $display("FAIL cf_block: got stall=%b stb1=%b cyc1=%b want 1/0/0", m.stall, s1.stb, s1.cyc); end
        total++; if (s0.cyc !== 1'b1) begin bad++; $display("FAIL cf_cyc0: got %b want 1", s0.cyc); end
        tick();
        slv(1, 32'h0, 0, 32'h0);
        #1;
        total++; if (m.ack !== 1'b1 || m.stall !== 1'b1 || s1.stb !== 1'b0) begin bad++; $display("FAIL cf_ack0: got ack=%b stall=%b stb1=%b want 1/1/0", m.ack, m.stall, s1.stb); end
        tick();
        slv(0, 32'h0, 0, 32'h0);
        #1;
        total++; if (s1.stb !== 1'b1 || m.stall !== 1'b0 || s1.cyc !== 1'b1 || s0.cyc !== 1'b0) begin bad++; $display("FAIL cf_issue1: got stb1=%b stall=%b cyc1=%b cyc0=%b want 1/0/1/0", s1.stb, m.stall, s1.cyc, s0.cyc); end
        tick();
        mreq(1, 0, 32'h1000_0000, 1);
        slv(1, 32'h0000_0BAD, 0, 32'h0);
        #1;
        total++; if (m.ack !== 1'b0) begin bad++; $display("FAIL cf_foreign_ack: got %b want 0", m.ack); end
        tick();
        slv(0, 32'h0, 1, 32'hCAFE_0001);
        #1;
        total++; if (m.ack !== 1'b1 || m.dat_r !== 32'hCAFE_0001) begin bad++; $display("FAIL cf_ack1: got ack=%b dat=%h want 1/cafe0001", m.ack, m.dat_r); end
        tick();
        mreq(0, 0, 32'h0, 0);
        slv(0, 32'h0, 0, 32'h0);
    endtask

    task automatic test_unmapped();
        tick();
        mreq(1, 1, 32'h2000_0000, 0);
        slv(0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF);
        #1;
        total++; if (s0.stb !== 1'b0 || s1.stb !== 1'b0) begin bad++; $display("FAIL um_nostb: got %b/%b want 0/0", s0.stb, s1.stb); end
        total++; if (m.stall !== 1'b0 || m.err !== 1'b0) begin bad++; $display("FAIL um_accept: got stall=%b err=%b want 0/0", m.stall, m.err); end
        tick();
        #1;
        total++; if (m.err !== 1'b1 || m.dat_r !== 32'h0) begin bad++; $display("FAIL um_err: got err=%b dat=%h want 1/00000000", m.err, m.dat_r); end
        total++; if (m.stall !== 1'b1 || s0.stb !== 1'b0) begin bad++; $display("FAIL um_stall: got stall=%b stb0=%b want 1/0", m.stall, s0.stb); end
        tick();
        mreq(1, 1, 32'h10, 0);
        s0.stall = 1'b1;
        #1;
        total++; if (m.err !== 1'b0) begin bad++; $display("FAIL um_err_once: got %b want 0", m.err); end
        total++; if (m.stall !== 1'b1 || s0.stb !== 1'b1) begin bad++; $display("FAIL slv_stall: got stall=%b stb0=%b want 1/1", m.stall, s0.stb); end
        tick();
        mreq(0, 0, 32'h0, 0);
        s0.stall = 1'b0;
        slv(0, 32'h0, 0, 32'h0);
    endtask

    task automatic test_cyc_drop();
        tick();
        mreq(1, 1, 32'h20, 0);
        tick();
        mreq(1, 1, 32'h24, 0);
        tick();
        mreq(0, 0, 32'h24, 0);
        slv(1, 32'h77, 0, 32'h0);
        #1;
        total++; if (m.ack !== 1'b0 || s0.cyc !== 1'b0) begin bad++; $display("FAIL cd_drop: got ack=%b cyc0=%b want 0/0", m.ack, s0.cyc); end
        tick();
        mreq(1, 0, 32'h24, 0);
        #1;
        total++; if (m.ack !== 1'b0 || s0.cyc !== 1'b0) begin bad++; $display("FAIL cd_late: got ack=%b cyc0=%b want 0/0", m.ack, s0.cyc); end
        tick();
        mreq(1, 1, 32'h30, 0);
        slv(0, 32'h0, 0, 32'h0);
        #1;
        total++; if (s0.stb !== 1'b1 || m.stall !== 1'b0) begin bad++; $display("FAIL cd_next: got stb0=%b stall=%b want 1/0", s0.stb, m.stall); end
        tick();
        mreq(1, 0, 32'h30, 0);
        slv(1, 32'h1234, 0, 32'h0);
        #1;
        total++; if (m.ack !== 1'b1 || m.dat_r !== 32'h1234) begin bad++; $display("FAIL cd_ack: got ack=%b dat=%h want 1/00001234", m.ack, m.dat_r); end
        tick();
        mreq(0, 0, 32'h0, 0);
        slv(0, 32'h0, 0, 32'h0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            tick();
            mreq(1, 1, 32'h40 + 32'(4 * i), 1);
        end
        tick();
        rst = 1'b0;
        slv(1, 32'h5, 0, 32'h0);
        #1;
        total++; if (s0.cyc !== 1'b0 || s0.stb !== 1'b0 || s1.cyc !== 1'b0) begin bad++; $display("FAIL rm_quiet: got cyc0=%b stb0=%b cyc1=%b want 0/0/0", s0.cyc, s0.stb, s1.cyc); end
        total++; if (m.ack !== 1'b0 || m.stall !== 1'b1) begin bad++; $display("FAIL rm_master: got ack=%b stall=%b want 0/1", m.ack, m.stall); end
        tick();
        rst = 1'b1;
        mreq(1, 0, 32'h40, 1);
        #1;
        total++; if (m.ack !== 1'b0 || s0.cyc !== 1'b0) begin bad++; $display("FAIL rm_late_ack: got ack=%b cyc0=%b want 0/0", m.ack, s0.cyc); end
        slv(0, 32'h0, 0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            mreq(1, 1, 32'h80 + 32'(4 * i), 1);
            #1;
            total++; if (m.stall !== 1'b0) begin bad++; $display("FAIL rm_refill%0d: got stall=%b want 0", i, m.stall); end
        end
        tick();
        #1;
        total++; if (m.stall !== 1'b1) begin bad++; $display("FAIL rm_refull: got stall=%b want 1", m.stall); end
        tick();
        mreq(0, 0, 32'h0, 0);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_conflict();
        test_unmapped();
        test_cyc_drop();
        test_reset_mid();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
